// File: rtl/pixie_dma_sequencer.sv
// pixie_dma_sequencer
//
// CPU-side front end of the PIXIE graphics core. Tracks frame timing in CPU
// machine cycles, raises the display interrupt and the EFx flag, and during
// active lines requests DMA-out cycles from the 1802, writing each accepted
// byte into the dual-port frame buffer at the line/byte address the display
// back end reads from.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   mc_tick      one-clk strobe per CPU machine cycle
//   disp_on      one-clk pulse: enable display (also clears dma_underrun)
//   disp_off     one-clk pulse: disable display (wins over disp_on)
//   dma_ack      one-clk strobe: CPU is executing a DMA-out cycle
//   bus_data     CPU data bus, sampled when dma_ack is high
//   dma_out_req  DMA-out request to the CPU
//   int_req      display interrupt request
//   efx          EF1 flag to the CPU
//   fb_write_en  frame buffer write strobe (one clk per accepted byte)
//   fb_addr      frame buffer write address {line[6:0], byte[2:0]}
//   fb_data      frame buffer write data
//   dma_underrun sticky: a line ended before all of its bytes were taken

module pixie_dma_sequencer #(
    parameter int unsigned CyclesPerLine   = 14,
    parameter int unsigned LinesPerFrame   = 262,
    parameter int unsigned ActiveStartLine = 80,
    parameter int unsigned ActiveVLines    = 128,
    parameter int unsigned BytesPerLine    = 8,
    parameter int unsigned DmaStartCycle   = 2,
    parameter int unsigned IntLines        = 2,
    parameter int unsigned EfxLeadLines    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mc_tick,
    input  logic       disp_on,
    input  logic       disp_off,
    input  logic       dma_ack,
    input  logic [7:0] bus_data,
    output logic       dma_out_req,
    output logic       int_req,
    output logic       efx,
    output logic       fb_write_en,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       dma_underrun
);

    localparam int unsigned CycW  = $clog2(CyclesPerLine);
    localparam int unsigned LineW = $clog2(LinesPerFrame);
    localparam int unsigned ByteW = $clog2(BytesPerLine + 1);

    localparam logic [CycW-1:0]  LastCycle  = CycW'(CyclesPerLine - 1);
    localparam logic [CycW-1:0]  StartCycle = CycW'(DmaStartCycle);
    localparam logic [LineW-1:0] LastLine   = LineW'(LinesPerFrame - 1);
    localparam logic [LineW-1:0] FirstLine  = LineW'(ActiveStartLine);
    localparam logic [ByteW-1:0] FullCount  = ByteW'(BytesPerLine);

    localparam int unsigned ActiveEndLine = ActiveStartLine + ActiveVLines;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } dma_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CycW-1:0]  cycle_q, cycle_d;
    logic [LineW-1:0] line_q, line_d;
    logic             enabled_q, enabled_d;
    dma_state_e       state_q, state_d;
    logic [ByteW-1:0] byte_idx_q, byte_idx_d;
    logic             underrun_q, underrun_d;
    logic             int_req_q, int_req_d;
    logic             efx_q, efx_d;
    logic             wr_en_q, wr_en_d;
    logic [9:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic in_window(input logic [LineW-1:0] line,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (32'(line) >= lo) && (32'(line) < hi);
    endfunction

    logic             line_wrap;
    logic             active;
    logic             start_ok;
    logic             dma_accept;
    logic             underrun_set;
    logic [ByteW-1:0] byte_cnt_next;
    logic [LineW-1:0] line_rel;

    assign line_wrap = mc_tick && (cycle_q == LastCycle);
    assign active    = in_window(line_q, ActiveStartLine, ActiveEndLine);
    // disp_off in the same clk as the start slot suppresses the request
    assign start_ok  = mc_tick && (cycle_q == StartCycle) && enabled_q && active && !disp_off;
    // Buffer line index; wraps modulo 128 through the [6:0] slice below
    assign line_rel  = line_q - FirstLine;

    // ------------------------------------------------------------------
    // Frame timing
    // ------------------------------------------------------------------
    always_comb begin
        cycle_d = cycle_q;
        line_d  = line_q;
        if (mc_tick) begin
            if (line_wrap) begin
                cycle_d = '0;
                line_d  = (line_q == LastLine) ? '0 : line_q + 1'b1;
            end else begin
                cycle_d = cycle_q + 1'b1;
            end
        end
    end

    always_comb begin
        enabled_d = enabled_q;
        if (disp_off) begin
            enabled_d = 1'b0;
        end else if (disp_on) begin
            enabled_d = 1'b1;
        end
    end

    // Flags are computed from next-state values so they line up with the
    // counters they describe rather than trailing them by a clk.
    always_comb begin
        int_req_d = enabled_d && in_window(line_d, ActiveStartLine - IntLines, ActiveStartLine);
        efx_d     = in_window(line_d, ActiveStartLine - EfxLeadLines, ActiveStartLine) ||
                    in_window(line_d, ActiveEndLine - EfxLeadLines, ActiveEndLine);
    end

    // ------------------------------------------------------------------
    // DMA request FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        byte_cnt_next = byte_idx_q;
        dma_accept    = 1'b0;
        underrun_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d    = StReq;
                    byte_idx_d = '0;
                end
            end
            StReq: begin
                dma_accept    = dma_ack;
                byte_cnt_next = byte_idx_q + ByteW'(dma_accept);
                byte_idx_d    = byte_cnt_next;
                if (disp_off) begin
                    state_d = StIdle;
                end else if (line_wrap) begin
                    // An ack in the wrap clk still counts toward the line.
                    // Even a completed line returns straight to idle here,
                    // otherwise DONE would miss this wrap and skip a line.
                    state_d      = StIdle;
                    underrun_set = (byte_cnt_next != FullCount);
                end else if (byte_cnt_next == FullCount) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (line_wrap) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A fresh underrun takes priority over a coincident clear
    always_comb begin
        underrun_d = underrun_q;
        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (disp_on) begin
            underrun_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer write path (one clk behind the accepted ack)
    // ------------------------------------------------------------------
    always_comb begin
        wr_en_d   = dma_accept;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (dma_accept) begin
            wr_addr_d = {line_rel[6:0], 3'(byte_idx_q)};
            wr_data_d = bus_data;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q    <= '0;
            line_q     <= '0;
            enabled_q  <= 1'b0;
            state_q    <= StIdle;
            byte_idx_q <= '0;
            underrun_q <= 1'b0;
            int_req_q  <= 1'b0;
            efx_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            cycle_q    <= cycle_d;
            line_q     <= line_d;
            enabled_q  <= enabled_d;
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            underrun_q <= underrun_d;
            int_req_q  <= int_req_d;
            efx_q      <= efx_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dma_out_req  = (state_q == StReq);
    assign int_req      = int_req_q;
    assign efx          = efx_q;
    assign fb_write_en  = wr_en_q;
    assign fb_addr      = wr_addr_q;
    assign fb_data      = wr_data_q;
    assign dma_underrun = underrun_q;

endmodule

// File: tb/tb_pixie_dma_sequencer.sv
// Testbench for pixie_dma_sequencer. A driver issues machine-cycle ticks,
// display pulses and DMA acks while keeping a small model of frame timing;
// each ack pushes its expected frame buffer write into a queue that an
// independent monitor pops whenever fb_write_en is seen.

module tb_pixie_dma_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       mc_tick;
    logic       disp_on;
    logic       disp_off;
    logic       dma_ack;
    logic [7:0] bus_data;
    logic       dma_out_req;
    logic       int_req;
    logic       efx;
    logic       fb_write_en;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       dma_underrun;

    pixie_dma_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mc_tick      (mc_tick),
        .disp_on      (disp_on),
        .disp_off     (disp_off),
        .dma_ack      (dma_ack),
        .bus_data     (bus_data),
        .dma_out_req  (dma_out_req),
        .int_req      (int_req),
        .efx          (efx),
        .fb_write_en  (fb_write_en),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .dma_underrun (dma_underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  writes_seen = 0;

    // Timing model (state after the most recent clk edge)
    int  m_cyc = 0;
    int  m_line = 0;
    bit  m_en = 0;
    bit  chk_now = 0;
    // Inputs presented for the coming edge, applied to the model after it
    bit  p_tick = 0, p_on = 0, p_off = 0;
    // Driver controls
    bit  tphase = 0;
    bit  req_on = 0, req_off = 0;
    bit  auto_ack = 1;
    int  ack_limit = 8;
    int  acks_this_req = 0;
    int  force_line = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (line %0d cyc %0d)",
                     name, act, exp, m_line, m_cyc);
        end
    endtask

    function automatic logic [7:0] pat(input logic [9:0] a);
        return 8'((32'(a) * 37 + 11) & 255);
    endfunction

    function automatic bit m_active(input int l);
        return (l >= 80) && (l < 208);
    endfunction

    function automatic bit exp_efx(input int l);
        return ((l >= 76) && (l < 80)) || ((l >= 204) && (l < 208));
    endfunction

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard on each write, checks levels mid-line
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (fb_write_en === 1'b1) begin
                writes_seen++;
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("fb_addr", 32'(fb_addr), 32'(e.addr));
                    check("fb_data", 32'(fb_data), 32'(e.data));
                end
            end
            if (chk_now) begin
                check("efx", 32'(efx), 32'(exp_efx(m_line)));
                check("int_req", 32'(int_req), 32'(m_en && (m_line == 78 || m_line == 79)));
                if (!(m_en && m_active(m_line))) begin
                    check("dma_out_req_idle", 32'(dma_out_req), 32'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: one clk per call
    // ------------------------------------------------------------------
    task automatic step();
        logic [9:0] a;
        @(posedge clk);
        chk_now = 0;
        if (p_off) m_en = 0;
        else if (p_on) m_en = 1;
        if (p_tick) begin
            if (m_cyc == 13) begin
                m_cyc  = 0;
                m_line = (m_line == 261) ? 0 : m_line + 1;
            end else begin
                m_cyc++;
            end
            if (m_cyc == 7) chk_now = 1;
        end
        #1;
        tphase  = ~tphase;
        mc_tick = tphase;
        dma_ack = 1'b0;
        if (dma_out_req !== 1'b1) acks_this_req = 0;
        if (auto_ack && dma_out_req === 1'b1 && acks_this_req < ack_limit) begin
            check("req_legal", 32'(m_en && m_active(m_line)), 32'd1);
            a        = {7'(m_line - 80), 3'(acks_this_req)};
            dma_ack  = 1'b1;
            bus_data = pat(a);
            exp_q.push_back('{addr: a, data: pat(a)});
            acks_this_req++;
        end else if (m_line == force_line && (m_cyc == 0 || m_cyc == 12)) begin
            // Spurious ack: idle at cyc 0, DONE (or disabled) at cyc 12
            dma_ack  = 1'b1;
            bus_data = 8'hEE;
        end
        disp_on  = req_on;
        disp_off = req_off;
        req_on   = 0;
        req_off  = 0;
        p_tick   = mc_tick;
        p_on     = disp_on;
        p_off    = disp_off;
    endtask

    task automatic run_until(input int line, input int cyc);
        int n;
        n = 0;
        while (!(m_line == line && m_cyc == cyc) && n < 20000) begin
            step();
            n++;
        end
        check("run_until_bound", 32'(n < 20000), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dma_out_req"}, 32'(dma_out_req), 32'd0);
        check({tag, "_int_req"}, 32'(int_req), 32'd0);
        check({tag, "_efx"}, 32'(efx), 32'd0);
        check({tag, "_fb_write_en"}, 32'(fb_write_en), 32'd0);
        check({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
        check({tag, "_fb_data"}, 32'(fb_data), 32'd0);
        check({tag, "_dma_underrun"}, 32'(dma_underrun), 32'd0);
    endtask

    initial begin
        int w0;
        int n;
        reset_n  = 1'b0;
        mc_tick  = 1'b0;
        disp_on  = 1'b0;
        disp_off = 1'b0;
        dma_ack  = 1'b0;
        bus_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // Frame without disp_on: EFx only, spurious acks on line 10
        force_line = 10;
        run_until(100, 0);
        run_until(0, 0);
        check("no_writes_disabled", 32'(writes_seen), 32'd0);

        // Full frame with immediate acks; spurious acks on line 90
        req_on     = 1;
        force_line = 90;
        w0 = writes_seen;
        run_until(100, 0);
        run_until(0, 0);
        check("frame_writes", 32'(writes_seen - w0), 32'd1024);
        check("frame_queue_empty", 32'(exp_q.size()), 32'd0);
        force_line = -1;

        // Underrun: only 5 acks on line 80
        ack_limit = 5;
        w0 = writes_seen;
        run_until(81, 0);
        ack_limit = 8;
        check("underrun_set", 32'(dma_underrun), 32'd1);
        check("underrun_line_writes", 32'(writes_seen - w0), 32'd5);
        run_until(84, 0);
        check("underrun_held", 32'(dma_underrun), 32'd1);
        req_on = 1;
        step();
        step();
        check("underrun_cleared", 32'(dma_underrun), 32'd0);

        // disp_off with disp_on in the same clk at byte 2 of line 100
        run_until(100, 0);
        ack_limit = 2;
        w0 = writes_seen;
        n = 0;
        while (acks_this_req < 2 && n < 200) begin
            step();
            n++;
        end
        check("line100_acks_bound", 32'(n < 200), 32'd1);
        req_on  = 1;
        req_off = 1;
        step();
        check("req_before_off", 32'(dma_out_req), 32'd1);
        step();
        check("req_after_off", 32'(dma_out_req), 32'd0);
        ack_limit = 8;
        run_until(0, 0);
        run_until(82, 0);
        check("off_writes", 32'(writes_seen - w0), 32'd2);
        check("off_no_underrun", 32'(dma_underrun), 32'd0);

        // Reset in the middle of a request, after bytes 0..2 of line 82
        req_on    = 1;
        ack_limit = 3;
        n = 0;
        while (acks_this_req < 3 && n < 200) begin
            step();
            n++;
        end
        check("reset_acks_bound", 32'(n < 200), 32'd1);
        step();
        step();
        check("pre_reset_req", 32'(dma_out_req), 32'd1);
        check("pre_reset_queue", 32'(exp_q.size()), 32'd0);
        #3;
        reset_n = 1'b0;
        mc_tick = 1'b0;
        dma_ack = 1'b0;
        #1;
        check_all_zero("midreq_reset");
        m_cyc = 0; m_line = 0; m_en = 0; chk_now = 0;
        p_tick = 0; p_on = 0; p_off = 0; tphase = 0; acks_this_req = 0;
        ack_limit = 8;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        w0 = writes_seen;
        run_until(120, 0);
        check("post_reset_writes", 32'(writes_seen - w0), 32'd0);
        check("post_reset_req", 32'(dma_out_req), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
